// File: rtl/gs_mem_arbiter.sv
// -----------------------------------------------------------------------------
// gs_mem_arbiter
//
// Shares the single req/gnt/rvalid memory port of the GoldenSnitch core between
// the instruction-fetch unit (IF) and the load/store unit (LSU). Only one
// transaction may be outstanding at a time. The LSU normally wins so that
// load-to-use stalls clear quickly. A streak limiter hands the next contested
// grant to IF after MAX_LSU_STREAK back-to-back LSU grants, so IF cannot starve.
// A flush from the controller squashes the response of an in-flight IF fetch.
//
// Optional feature (macro GS_MEM_ARB_PERF_EN): adds two free-running 32-bit
// performance counters, perf_conflict_o and perf_if_wait_o. With the macro
// undefined the ports and counters do not exist.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   if_req_i/addr_i   IF read request and address
//   if_gnt_o          IF request accepted by memory
//   if_rvalid_o       IF read data valid (suppressed after a flush)
//   flush_if_i        squash the in-flight IF response
//   lsu_req_i/we_i/be_i/addr_i/wdata_i   LSU request and payload
//   lsu_gnt_o         LSU request accepted by memory
//   lsu_rvalid_o      LSU response valid (reads and writes)
//   rdata_o           mem_rdata_i broadcast, qualified by the *_rvalid_o
//   mem_*_o           request side of the shared memory port
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i  response side of the memory port
//   busy_o            a transaction is pending or outstanding
//   perf_conflict_o   (perf build) idle cycles with both requests high
//   perf_if_wait_o    (perf build) cycles IF waits without ownership or grant
// -----------------------------------------------------------------------------
module gs_mem_arbiter #(
  parameter int unsigned MAX_LSU_STREAK = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  input  logic                flush_if_i,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [DATA_W/8-1:0] lsu_be_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
`ifdef GS_MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_conflict_o,
  output logic [31:0]         perf_if_wait_o
`endif
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_WAIT_RESP
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LSU
  } owner_e;

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [3:0] streak_q, streak_d;
  logic       drop_q, drop_d;

  logic       sel_if;
  logic       sel_lsu;
  logic       streak_limit;
  logic       resp_valid;

  // Pick which requester drives the memory port this cycle. In IDLE the
  // choice is made fresh; in HOLD the owner stays locked so a higher-priority
  // request cannot steal a request the memory has already seen. The reset
  // term keeps every request output quiet while rst is held low.
  always_comb begin
    sel_if       = 1'b0;
    sel_lsu      = 1'b0;
    streak_limit = if_req_i && (streak_q == STREAK_MAX);
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          if (lsu_req_i && !streak_limit) begin
            sel_lsu = 1'b1;
          end else if (if_req_i) begin
            sel_if = 1'b1;
          end
        end
        ST_HOLD: begin
          sel_lsu = (owner_q == OWN_LSU);
          sel_if  = (owner_q == OWN_IF);
        end
        default: ;
      endcase
    end
  end

  // Memory port mux. IF fetches are always full-width reads.
  always_comb begin
    mem_req_o   = sel_if || sel_lsu;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (sel_lsu) begin
      mem_we_o    = lsu_we_i;
      mem_be_o    = lsu_be_i;
      mem_addr_o  = lsu_addr_i;
      mem_wdata_o = lsu_wdata_i;
    end else if (sel_if) begin
      mem_be_o   = '1;
      mem_addr_o = if_addr_i;
    end
  end

  // Grants pass straight through from memory to the selected requester.
  // Responses are only honoured while a granted transaction is outstanding;
  // an IF response is dropped if a flush arrived earlier or arrives now.
  always_comb begin
    if_gnt_o     = sel_if && mem_gnt_i;
    lsu_gnt_o    = sel_lsu && mem_gnt_i;
    resp_valid   = rst && (state_q == ST_WAIT_RESP) && mem_rvalid_i;
    lsu_rvalid_o = resp_valid && (owner_q == OWN_LSU);
    if_rvalid_o  = resp_valid && (owner_q == OWN_IF) && !drop_q && !flush_if_i;
    rdata_o      = mem_rdata_i;
    busy_o       = (state_q != ST_IDLE);
  end

  // Next-state logic for the transaction FSM, the squash flag and the
  // LSU streak counter.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    drop_d   = drop_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_if || sel_lsu) begin
          owner_d = sel_lsu ? OWN_LSU : OWN_IF;
          drop_d  = 1'b0;
          state_d = mem_gnt_i ? ST_WAIT_RESP : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if ((owner_q == OWN_IF) && flush_if_i) begin
          drop_d = 1'b1;
        end
        if (mem_gnt_i) begin
          state_d = ST_WAIT_RESP;
        end
      end
      ST_WAIT_RESP: begin
        if ((owner_q == OWN_IF) && flush_if_i) begin
          drop_d = 1'b1;
        end
        if (mem_rvalid_i) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    // The streak only grows while IF is actually being held off.
    if (lsu_gnt_o) begin
      if (if_req_i) begin
        streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
      end else begin
        streak_d = 4'd0;
      end
    end else if (if_gnt_o) begin
      streak_d = 4'd0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      streak_q <= 4'd0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
    end
  end

`ifdef GS_MEM_ARB_PERF_EN
  logic [31:0] perf_conflict_q, perf_conflict_d;
  logic [31:0] perf_if_wait_q, perf_if_wait_d;

  // Conflict: both units asking during an arbitration cycle. IF wait: IF is
  // asking but neither owns the port nor receives a grant this cycle.
  always_comb begin
    perf_conflict_d = perf_conflict_q;
    perf_if_wait_d  = perf_if_wait_q;
    if ((state_q == ST_IDLE) && if_req_i && lsu_req_i) begin
      perf_conflict_d = perf_conflict_q + 32'd1;
    end
    if (if_req_i && (owner_q != OWN_IF) && !if_gnt_o) begin
      perf_if_wait_d = perf_if_wait_q + 32'd1;
    end
  end

  // Counter registers; they wrap naturally on overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_conflict_q <= 32'd0;
      perf_if_wait_q  <= 32'd0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
      perf_if_wait_q  <= perf_if_wait_d;
    end
  end

  assign perf_conflict_o = perf_conflict_q;
  assign perf_if_wait_o  = perf_if_wait_q;
`endif

endmodule

// File: tb/tb_gs_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gs_mem_arbiter
//
// Self-checking bench for gs_mem_arbiter. Directed scenarios cover reset,
// a plain IF fetch, LSU priority, the streak limiter, owner locking in HOLD,
// IF flush squashing and reset during an outstanding transaction. A random
// phase compares the DUT against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_gs_mem_arbiter;

  localparam int MAX_STREAK = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;

  logic              clk;
  logic              rst;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic              flush_if_i;
  logic              lsu_req_i;
  logic              lsu_we_i;
  logic [BE_W-1:0]   lsu_be_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [DATA_W-1:0] lsu_wdata_i;
  logic              lsu_gnt_o;
  logic              lsu_rvalid_o;
  logic [DATA_W-1:0] rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              busy_o;
`ifdef GS_MEM_ARB_PERF_EN
  logic [31:0]       perf_conflict_o;
  logic [31:0]       perf_if_wait_o;
`endif

  int check_count = 0;
  int error_count = 0;

  gs_mem_arbiter #(
    .MAX_LSU_STREAK(MAX_STREAK),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req_i(if_req_i),
    .if_addr_i(if_addr_i),
    .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o),
    .flush_if_i(flush_if_i),
    .lsu_req_i(lsu_req_i),
    .lsu_we_i(lsu_we_i),
    .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i),
    .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o),
    .rdata_o(rdata_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
`ifdef GS_MEM_ARB_PERF_EN
    ,
    .perf_conflict_o(perf_conflict_o),
    .perf_if_wait_o(perf_if_wait_o)
`endif
  );

  // Free-running clock; inputs change on the falling edge, outputs are
  // sampled two time units later, well before the next rising edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if something stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_inputs();
    if_req_i     = 1'b0;
    if_addr_i    = '0;
    flush_if_i   = 1'b0;
    lsu_req_i    = 1'b0;
    lsu_we_i     = 1'b0;
    lsu_be_i     = '0;
    lsu_addr_i   = '0;
    lsu_wdata_i  = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Outputs must stay quiet under reset even with busy-looking inputs.
  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    if_req_i     = 1'b1;
    if_addr_i    = 32'h0000_0040;
    lsu_req_i    = 1'b1;
    lsu_addr_i   = 32'h0000_0080;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234_5678;
    #12;
    check_count++; if (mem_req_o !== 1'b0) begin error_count++; $display("[TB] FAIL reset_mem_req: got %b, expected 0", mem_req_o); end
    check_count++; if (if_gnt_o !== 1'b0) begin error_count++; $display("[TB] FAIL reset_if_gnt: got %b, expected 0", if_gnt_o); end
    check_count++; if (lsu_gnt_o !== 1'b0) begin error_count++; $display("[TB] FAIL reset_lsu_gnt: got %b, expected 0", lsu_gnt_o); end
    check_count++; if (if_rvalid_o !== 1'b0 || lsu_rvalid_o !== 1'b0) begin error_count++; $display("[TB] FAIL reset_rvalid: got %b%b, expected 00", if_rvalid_o, lsu_rvalid_o); end
    check_count++; if (busy_o !== 1'b0) begin error_count++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy_o); end
    check_count++; if (mem_addr_o !== 32'h0) begin error_count++; $display("[TB] FAIL reset_mem_addr: got %h, expected 0", mem_addr_o); end
    check_count++; if (rdata_o !== 32'h1234_5678) begin error_count++; $display("[TB] FAIL reset_rdata: got %h, expected 12345678", rdata_o); end
  endtask

  // IF-only fetch, granted immediately, answered on the next cycle.
  task automatic test_if_read();
    do_reset();
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h100; mem_gnt_i = 1'b1;
    #2;
    check_count++; if (if_gnt_o !== 1'b1) begin error_count++; $display("[TB] FAIL if_read_gnt: got %b, expected 1", if_gnt_o); end
    check_count++; if (mem_addr_o !== 32'h100) begin error_count++; $display("[TB] FAIL if_read_addr: got %h, expected 100", mem_addr_o); end
    check_count++; if (mem_we_o !== 1'b0 || mem_be_o !== 4'hF) begin error_count++; $display("[TB] FAIL if_read_we_be: got %b/%h, expected 0/f", mem_we_o, mem_be_o); end
    check_count++; if (lsu_gnt_o !== 1'b0) begin error_count++; $display("[TB] FAIL if_read_lsu_gnt: got %b, expected 0", lsu_gnt_o); end
    @(negedge clk);
    if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #2;
    check_count++; if (if_rvalid_o !== 1'b1) begin error_count++; $display("[TB] FAIL if_read_rvalid: got %b, expected 1", if_rvalid_o); end
    check_count++; if (rdata_o !== 32'hDEAD_BEEF) begin error_count++; $display("[TB] FAIL if_read_rdata: got %h, expected deadbeef", rdata_o); end
    check_count++; if (lsu_rvalid_o !== 1'b0 || mem_req_o !== 1'b0) begin error_count++; $display("[TB] FAIL if_read_quiet: got lsu_rvalid=%b mem_req=%b, expected 0/0", lsu_rvalid_o, mem_req_o); end
    @(negedge clk);
    idle_inputs();
    #2;
    check_count++; if (busy_o !== 1'b0) begin error_count++; $display("[TB] FAIL if_read_idle: got busy=%b, expected 0", busy_o); end
  endtask

  // Simultaneous requests: LSU first, IF at the next free arbitration.
  task automatic test_lsu_priority();
    do_reset();
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h300;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'h3; lsu_addr_i = 32'h200; lsu_wdata_i = 32'hCAFE_0001;
    mem_gnt_i = 1'b1;
    #2;
    check_count++; if (lsu_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin error_count++; $display("[TB] FAIL prio_gnt: got lsu=%b if=%b, expected 1/0", lsu_gnt_o, if_gnt_o); end
    check_count++; if (mem_we_o !== 1'b1 || mem_be_o !== 4'h3 || mem_addr_o !== 32'h200) begin error_count++; $display("[TB] FAIL prio_payload: got %b/%h/%h, expected 1/3/200", mem_we_o, mem_be_o, mem_addr_o); end
    check_count++; if (mem_wdata_o !== 32'hCAFE_0001) begin error_count++; $display("[TB] FAIL prio_wdata: got %h, expected cafe0001", mem_wdata_o); end
    @(negedge clk);
    lsu_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    #2;
    check_count++; if (lsu_rvalid_o !== 1'b1 || if_rvalid_o !== 1'b0) begin error_count++; $display("[TB] FAIL prio_resp: got lsu=%b if=%b, expected 1/0", lsu_rvalid_o, if_rvalid_o); end
    @(negedge clk);
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
    #2;
    check_count++; if (if_gnt_o !== 1'b1 || mem_addr_o !== 32'h300) begin error_count++; $display("[TB] FAIL prio_if_next: got gnt=%b addr=%h, expected 1/300", if_gnt_o, mem_addr_o); end
    @(negedge clk);
    if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    @(negedge clk);
    idle_inputs();
  endtask

  // Both units request continuously: four LSU grants, then IF, then LSU.
  task automatic test_streak_order();
    logic [5:0] exp_lsu;
    exp_lsu = 6'b101111;
    do_reset();
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h700;
    lsu_req_i = 1'b1; lsu_addr_i = 32'h800; lsu_be_i = 4'hF;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #2;
      check_count++; if (lsu_gnt_o !== exp_lsu[k] || if_gnt_o !== !exp_lsu[k]) begin error_count++; $display("[TB] FAIL streak_grant_%0d: got lsu=%b if=%b, expected lsu=%b", k, lsu_gnt_o, if_gnt_o, exp_lsu[k]); end
      @(negedge clk);
      #2;
      check_count++; if (lsu_rvalid_o !== exp_lsu[k] || if_rvalid_o !== !exp_lsu[k]) begin error_count++; $display("[TB] FAIL streak_resp_%0d: got lsu=%b if=%b, expected lsu=%b", k, lsu_rvalid_o, if_rvalid_o, exp_lsu[k]); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  // IF owns a stalled request; a later LSU request must not preempt it.
  task automatic test_hold_lock();
    do_reset();
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h400; mem_gnt_i = 1'b0;
    #2;
    check_count++; if (mem_req_o !== 1'b1 || if_gnt_o !== 1'b0) begin error_count++; $display("[TB] FAIL hold_first: got req=%b gnt=%b, expected 1/0", mem_req_o, if_gnt_o); end
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h500; lsu_be_i = 4'h1;
      #2;
      check_count++; if (mem_addr_o !== 32'h400 || mem_we_o !== 1'b0) begin error_count++; $display("[TB] FAIL hold_lock_%0d: got addr=%h we=%b, expected 400/0", k, mem_addr_o, mem_we_o); end
    end
    @(negedge clk);
    mem_gnt_i = 1'b1;
    #2;
    check_count++; if (if_gnt_o !== 1'b1 || lsu_gnt_o !== 1'b0 || mem_addr_o !== 32'h400) begin error_count++; $display("[TB] FAIL hold_grant: got if=%b lsu=%b addr=%h, expected 1/0/400", if_gnt_o, lsu_gnt_o, mem_addr_o); end
    @(negedge clk);
    if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    #2;
    check_count++; if (if_rvalid_o !== 1'b1) begin error_count++; $display("[TB] FAIL hold_if_resp: got %b, expected 1", if_rvalid_o); end
    @(negedge clk);
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
    #2;
    check_count++; if (lsu_gnt_o !== 1'b1 || mem_addr_o !== 32'h500) begin error_count++; $display("[TB] FAIL hold_lsu_next: got gnt=%b addr=%h, expected 1/500", lsu_gnt_o, mem_addr_o); end
    @(negedge clk);
    lsu_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    #2;
    check_count++; if (lsu_rvalid_o !== 1'b1) begin error_count++; $display("[TB] FAIL hold_lsu_resp: got %b, expected 1", lsu_rvalid_o); end
    @(negedge clk);
    idle_inputs();
  endtask

  // Flush squashes only the in-flight IF response and then clears.
  task automatic test_flush();
    do_reset();
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'h600; mem_gnt_i = 1'b1;
    #2;
    check_count++; if (if_gnt_o !== 1'b1) begin error_count++; $display("[TB] FAIL flush_gnt: got %b, expected 1", if_gnt_o); end
    @(negedge clk);
    if_req_i = 1'b0; mem_gnt_i = 1'b0; flush_if_i = 1'b1;
    #2;
    check_count++; if (busy_o !== 1'b1 || if_rvalid_o !== 1'b0) begin error_count++; $display("[TB] FAIL flush_wait: got busy=%b rvalid=%b, expected 1/0", busy_o, if_rvalid_o); end
    @(negedge clk);
    flush_if_i = 1'b0; mem_rvalid_i = 1'b1;
    #2;
    check_count++; if (if_rvalid_o !== 1'b0) begin error_count++; $display("[TB] FAIL flush_squash: got %b, expected 0", if_rvalid_o); end
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    #2;
    check_count++; if (busy_o !== 1'b0) begin error_count++; $display("[TB] FAIL flush_idle: got busy=%b, expected 0", busy_o); end
    @(negedge clk);
    if_req_i = 1'b1; mem_gnt_i = 1'b1;
    @(negedge clk);
    if_req_i = 1'b0; mem_gnt_i = 1'b0; flush_if_i = 1'b1; mem_rvalid_i = 1'b1;
    #2;
    check_count++; if (if_rvalid_o !== 1'b0) begin error_count++; $display("[TB] FAIL flush_same_cycle: got %b, expected 0", if_rvalid_o); end
    @(negedge clk);
    flush_if_i = 1'b0; mem_rvalid_i = 1'b0; if_req_i = 1'b1; mem_gnt_i = 1'b1;
    @(negedge clk);
    if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    #2;
    check_count++; if (if_rvalid_o !== 1'b1) begin error_count++; $display("[TB] FAIL flush_cleared: got %b, expected 1", if_rvalid_o); end
    @(negedge clk);
    mem_rvalid_i = 1'b0; lsu_req_i = 1'b1; lsu_addr_i = 32'h900; mem_gnt_i = 1'b1;
    @(negedge clk);
    lsu_req_i = 1'b0; mem_gnt_i = 1'b0; flush_if_i = 1'b1; mem_rvalid_i = 1'b1;
    #2;
    check_count++; if (lsu_rvalid_o !== 1'b1) begin error_count++; $display("[TB] FAIL flush_lsu_owner: got %b, expected 1", lsu_rvalid_o); end
    @(negedge clk);
    idle_inputs();
  endtask

  // Reset while an LSU response is outstanding and the streak is saturated.
  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    if_req_i = 1'b1; if_addr_i = 32'hA00;
    lsu_req_i = 1'b1; lsu_addr_i = 32'hB00; lsu_be_i = 4'hF;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    repeat (6) @(negedge clk);
    #2;
    check_count++; if (lsu_gnt_o !== 1'b1) begin error_count++; $display("[TB] FAIL rstmid_fourth: got %b, expected 1", lsu_gnt_o); end
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_count++; if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin error_count++; $display("[TB] FAIL rstmid_state: got busy=%b req=%b, expected 0/0", busy_o, mem_req_o); end
    check_count++; if (lsu_rvalid_o !== 1'b0 || if_rvalid_o !== 1'b0) begin error_count++; $display("[TB] FAIL rstmid_rvalid: got lsu=%b if=%b, expected 0/0", lsu_rvalid_o, if_rvalid_o); end
    @(negedge clk);
    rst = 1'b1;
    #2;
    check_count++; if (lsu_gnt_o !== 1'b1 || if_gnt_o !== 1'b0) begin error_count++; $display("[TB] FAIL rstmid_streak: got lsu=%b if=%b, expected 1/0", lsu_gnt_o, if_gnt_o); end
    check_count++; if (lsu_rvalid_o !== 1'b0) begin error_count++; $display("[TB] FAIL rstmid_no_resp: got %b, expected 0", lsu_rvalid_o); end
    @(negedge clk);
    idle_inputs();
  endtask

  // Random traffic against a transaction-level reference: at most one
  // transaction exists, it is either waiting for a grant or for a response.
  task automatic test_random();
    bit          txn_valid, txn_granted, txn_lsu, txn_drop;
    bit          if_hold, lsu_hold;
    bit          e_req, e_ifg, e_lg, e_ifr, e_lr, pick_lsu, completing;
    int          streak;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    txn_valid = 0; txn_granted = 0; txn_lsu = 0; txn_drop = 0;
    if_hold = 0; lsu_hold = 0; streak = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!if_hold) begin
        if_req_i  = ($urandom_range(0, 2) != 0);
        if_addr_i = $urandom;
      end
      if (!lsu_hold) begin
        lsu_req_i   = ($urandom_range(0, 2) != 0);
        lsu_we_i    = 1'($urandom_range(0, 1));
        lsu_be_i    = 4'($urandom);
        lsu_addr_i  = $urandom;
        lsu_wdata_i = $urandom;
      end
      flush_if_i   = ($urandom_range(0, 7) == 0);
      mem_gnt_i    = ($urandom_range(0, 2) != 0);
      mem_rvalid_i = 1'($urandom_range(0, 1));
      mem_rdata_i  = $urandom;
      #2;
      e_req = 0; e_ifr = 0; e_lr = 0; pick_lsu = 0; completing = 0;
      if (!txn_valid) begin
        if (lsu_req_i && !(if_req_i && streak == MAX_STREAK)) begin
          e_req = 1; pick_lsu = 1;
        end else if (if_req_i) begin
          e_req = 1;
        end
      end else if (!txn_granted) begin
        e_req = 1; pick_lsu = txn_lsu;
      end else if (mem_rvalid_i) begin
        completing = 1;
        if (txn_lsu) e_lr = 1;
        else e_ifr = !(txn_drop || flush_if_i);
      end
      e_ifg = e_req && !pick_lsu && mem_gnt_i;
      e_lg  = e_req && pick_lsu && mem_gnt_i;
      e_we    = pick_lsu ? lsu_we_i : 1'b0;
      e_be    = pick_lsu ? lsu_be_i : 4'hF;
      e_addr  = pick_lsu ? lsu_addr_i : if_addr_i;
      e_wdata = pick_lsu ? lsu_wdata_i : 32'h0;

      check_count++; if (mem_req_o !== e_req) begin error_count++; $display("[TB] FAIL rnd_mem_req cyc %0d: got %b, expected %b", cyc, mem_req_o, e_req); end
      check_count++; if (if_gnt_o !== e_ifg) begin error_count++; $display("[TB] FAIL rnd_if_gnt cyc %0d: got %b, expected %b", cyc, if_gnt_o, e_ifg); end
      check_count++; if (lsu_gnt_o !== e_lg) begin error_count++; $display("[TB] FAIL rnd_lsu_gnt cyc %0d: got %b, expected %b", cyc, lsu_gnt_o, e_lg); end
      check_count++; if (if_rvalid_o !== e_ifr) begin error_count++; $display("[TB] FAIL rnd_if_rvalid cyc %0d: got %b, expected %b", cyc, if_rvalid_o, e_ifr); end
      check_count++; if (lsu_rvalid_o !== e_lr) begin error_count++; $display("[TB] FAIL rnd_lsu_rvalid cyc %0d: got %b, expected %b", cyc, lsu_rvalid_o, e_lr); end
      check_count++; if (busy_o !== txn_valid) begin error_count++; $display("[TB] FAIL rnd_busy cyc %0d: got %b, expected %b", cyc, busy_o, txn_valid); end
      check_count++; if (rdata_o !== mem_rdata_i) begin error_count++; $display("[TB] FAIL rnd_rdata cyc %0d: got %h, expected %h", cyc, rdata_o, mem_rdata_i); end
      if (e_req) begin
        check_count++; if (mem_addr_o !== e_addr || mem_we_o !== e_we) begin error_count++; $display("[TB] FAIL rnd_addr_we cyc %0d: got %h/%b, expected %h/%b", cyc, mem_addr_o, mem_we_o, e_addr, e_we); end
        check_count++; if (mem_be_o !== e_be || mem_wdata_o !== e_wdata) begin error_count++; $display("[TB] FAIL rnd_be_wdata cyc %0d: got %h/%h, expected %h/%h", cyc, mem_be_o, mem_wdata_o, e_be, e_wdata); end
      end

      if (completing) begin
        txn_valid = 0; txn_granted = 0; txn_drop = 0;
      end else begin
        if (!txn_valid && e_req) begin
          txn_valid = 1; txn_lsu = pick_lsu; txn_granted = 0; txn_drop = 0;
        end else if (txn_valid && !txn_lsu && flush_if_i) begin
          txn_drop = 1;
        end
        if (e_ifg || e_lg) txn_granted = 1;
      end
      if (e_lg) streak = if_req_i ? ((streak + 1 > MAX_STREAK) ? MAX_STREAK : streak + 1) : 0;
      else if (e_ifg) streak = 0;
      if_hold  = if_req_i && !e_ifg;
      lsu_hold = lsu_req_i && !e_lg;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_lsu_priority();
    test_streak_order();
    test_hold_lock();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
